// File: rtl/spmp_csr_file.sv
// SPMP CSR responder: spmpcfg/spmpaddr storage, WARL legalisation, clear-all sweep and flush pulse.
// Build with SPMP_SWITCH_EN defined to add the spmpswitch register (request kind 2).
package riscv;
    localparam int unsigned SPMP_N_ENTRIES = 64;
    typedef enum logic [1:0] {OFF = 2'd0, TOR = 2'd1, NA4 = 2'd2, NAPOT = 2'd3} spmp_addr_mode_t;
    typedef struct packed {
        logic            s;
        logic [1:0]      reserved;
        spmp_addr_mode_t addr_mode;
        logic            x;
        logic            w;
        logic            r;
    } spmpcfg_t;
    typedef logic [53:0] spmpaddr_t;
endpackage

module spmp_csr_file #(
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned PLEN       = 56
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [1:0]       req_kind_i,
    input  logic [5:0]       req_idx_i,
    input  logic [63:0]      req_wdata_i,
    output logic             resp_valid_o,
    output logic [63:0]      resp_rdata_o,
    output logic             resp_err_o,
    output riscv::spmpcfg_t  spmpcfg_o  [riscv::SPMP_N_ENTRIES],
    output riscv::spmpaddr_t spmpaddr_o [riscv::SPMP_N_ENTRIES],
    output logic             flush_o
);
    localparam int unsigned N_SLOTS   = riscv::SPMP_N_ENTRIES;
    localparam int unsigned BYTE_W    = 32'd8;
    localparam logic [53:0] ADDR_MASK = 54'((64'd1 << (PLEN - 32'd2)) - 64'd1);
    localparam logic [5:0]  LAST_IDX  = 6'(NR_ENTRIES - 32'd1);
`ifdef SPMP_SWITCH_EN
    localparam logic [63:0] ENTRY_MASK = (64'd1 << NR_ENTRIES) - 64'd1;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, CLEAR = 2'd2} state_t;

    state_t      state_r, state_s;
    logic [7:0]  cfg_r  [N_SLOTS];
    logic [53:0] addr_r [N_SLOTS];
    logic [5:0]  cnt_r;
    logic        resp_valid_r, resp_err_r, flush_r;
    logic [63:0] resp_rdata_r;
    logic        accept_s, start_clear_s, clear_done_s, err_s, changed_s;
    logic [63:0] rdata_s;
    int unsigned base_s;
`ifdef SPMP_SWITCH_EN
    logic [63:0] switch_r;
`endif

    // Reserved bits [6:5] are hard-wired to zero in every stored cfg byte.
    function automatic logic [7:0] cfg_legalise(input logic [7:0] raw);
        return raw & 8'h9F;
    endfunction

    assign accept_s      = req_valid_i && (state_r == IDLE);
    assign start_clear_s = accept_s && (req_kind_i == 2'd3) && (NR_ENTRIES != 32'd0);
    assign clear_done_s  = (state_r == CLEAR) && (cnt_r == LAST_IDX);

    // Request decode: legality, pre-write read data and whether a write would alter any stored bit.
    always_comb begin
        err_s     = 1'b0;
        rdata_s   = 64'd0;
        changed_s = 1'b0;
        base_s    = 32'(req_idx_i) * 32'd4;
        case (req_kind_i)
            2'd0: begin
                if (req_idx_i[0] || (base_s >= NR_ENTRIES)) begin
                    err_s = 1'b1;
                end else begin
                    for (int unsigned j = 32'd0; j < 32'd8; j++) begin
                        if ((base_s + j) < NR_ENTRIES) begin
                            rdata_s[BYTE_W*j +: BYTE_W] = cfg_r[6'(base_s + j)];
                            changed_s = changed_s |
                                (cfg_legalise(req_wdata_i[BYTE_W*j +: BYTE_W]) != cfg_r[6'(base_s + j)]);
                        end else begin
                            rdata_s[BYTE_W*j +: BYTE_W] = 8'd0;
                        end
                    end
                end
            end
            2'd1: begin
                if (32'(req_idx_i) >= NR_ENTRIES) begin
                    err_s = 1'b1;
                end else begin
                    rdata_s   = {10'd0, addr_r[req_idx_i]};
                    changed_s = (req_wdata_i[53:0] & ADDR_MASK) != addr_r[req_idx_i];
                end
            end
            2'd2: begin
`ifdef SPMP_SWITCH_EN
                if ((NR_ENTRIES != 32'd0) && (req_idx_i == 6'd0)) begin
                    rdata_s   = switch_r;
                    changed_s = (req_wdata_i & ENTRY_MASK) != switch_r;
                end else if ((NR_ENTRIES == 32'd64) && (req_idx_i == 6'd1)) begin
                    rdata_s = 64'd0;
                end else begin
                    err_s = 1'b1;
                end
`else
                err_s = 1'b1;
`endif
            end
            default: err_s = (NR_ENTRIES == 32'd0);
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: single-cycle response, or an entry-by-entry sweep before the response.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_clear_s) begin
                    state_s = CLEAR;
                end else if (accept_s) begin
                    state_s = RESP;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                if (clear_done_s) begin
                    state_s = RESP;
                end else begin
                    state_s = CLEAR;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // CSR state, sweep counter and registered response/flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 32'd0; i < N_SLOTS; i++) begin
                cfg_r[i]  <= 8'd0;
                addr_r[i] <= 54'd0;
            end
            cnt_r        <= 6'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 64'd0;
            flush_r      <= 1'b0;
`ifdef SPMP_SWITCH_EN
            switch_r     <= 64'd0;
`endif
        end else begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 64'd0;
            flush_r      <= 1'b0;
            if (accept_s && !start_clear_s) begin
                resp_valid_r <= 1'b1;
                resp_err_r   <= err_s;
                resp_rdata_r <= rdata_s;
                flush_r      <= req_we_i && !err_s && changed_s;
                if (req_we_i && !err_s) begin
                    case (req_kind_i)
                        2'd0: begin
                            for (int unsigned j = 32'd0; j < 32'd8; j++) begin
                                if ((base_s + j) < NR_ENTRIES) begin
                                    cfg_r[6'(base_s + j)] <= cfg_legalise(req_wdata_i[BYTE_W*j +: BYTE_W]);
                                end
                            end
                        end
                        2'd1: addr_r[req_idx_i] <= req_wdata_i[53:0] & ADDR_MASK;
`ifdef SPMP_SWITCH_EN
                        2'd2: begin
                            if (req_idx_i == 6'd0) begin
                                switch_r <= req_wdata_i & ENTRY_MASK;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            if (start_clear_s) begin
                cnt_r <= 6'd0;
            end
            if (state_r == CLEAR) begin
                cfg_r[cnt_r]  <= 8'd0;
                addr_r[cnt_r] <= 54'd0;
                cnt_r         <= cnt_r + 6'd1;
                if (clear_done_s) begin
                    resp_valid_r <= 1'b1;
                    flush_r      <= 1'b1;
`ifdef SPMP_SWITCH_EN
                    switch_r     <= 64'd0;
`endif
                end
            end
        end
    end

    assign req_ready_o  = (state_r == IDLE);
    assign resp_valid_o = resp_valid_r;
    assign resp_rdata_o = resp_rdata_r;
    assign resp_err_o   = resp_err_r;
    assign flush_o      = flush_r;

    // Unimplemented slots tie to zero; a cleared switch bit presents addr_mode OFF.
    for (genvar i = 0; i < N_SLOTS; i++) begin : g_entry
        if (i < NR_ENTRIES) begin : g_live
`ifdef SPMP_SWITCH_EN
            assign spmpcfg_o[i] = riscv::spmpcfg_t'(switch_r[i] ? cfg_r[i] : (cfg_r[i] & 8'hE7));
`else
            assign spmpcfg_o[i] = riscv::spmpcfg_t'(cfg_r[i]);
`endif
            assign spmpaddr_o[i] = addr_r[i];
        end else begin : g_tied
            assign spmpcfg_o[i]  = '0;
            assign spmpaddr_o[i] = '0;
        end
    end
endmodule

// File: tb/tb_spmp_csr_file.sv
// Scoreboard bench for spmp_csr_file with NR_ENTRIES = 16, PLEN = 56; covers SPMP_SWITCH_EN when defined.
module tb_spmp_csr_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  kind = 2'd0;
    logic [5:0]  idx = 6'd0;
    logic [63:0] wdata = 64'd0;
    logic        ready, resp_valid, resp_err, flush;
    logic [63:0] resp_rdata;
    riscv::spmpcfg_t  cfg_o  [riscv::SPMP_N_ENTRIES];
    riscv::spmpaddr_t addr_o [riscv::SPMP_N_ENTRIES];

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
        logic        flush;
        int          due;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;

    spmp_csr_file #(.NR_ENTRIES(16), .PLEN(56)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
        .req_we_i(we), .req_kind_i(kind), .req_idx_i(idx), .req_wdata_i(wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .spmpcfg_o(cfg_o), .spmpaddr_o(addr_o), .flush_o(flush)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, expv);
        end
    endtask

    // Monitor: every response must match the oldest scoreboard entry, including its arrival cycle.
    exp_t  mon_e;
    string mon_n;
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            check("resp_pending", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                check({mon_n, "_rdata"}, resp_rdata, mon_e.rdata);
                check({mon_n, "_err"}, {63'd0, resp_err}, {63'd0, mon_e.err});
                check({mon_n, "_flush"}, {63'd0, flush}, {63'd0, mon_e.flush});
                check({mon_n, "_latency"}, 64'(cyc), 64'(mon_e.due));
            end
        end else if (flush === 1'b1) begin
            check("flush_without_resp", {63'd0, flush}, 64'd0);
        end
    end

    task automatic push_exp(input logic [63:0] er, input logic ee, input logic ef, input int lat, input string nm);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        e.flush = ef;
        e.due   = cyc + lat - 1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic wait_drain(input string nm);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(posedge clk);
            guard++;
        end
        check({nm, "_resp_seen"}, {63'd0, exp_q.size() == 0}, 64'd1);
        exp_q.delete();
        name_q.delete();
    endtask

    task automatic issue(input logic [1:0] k, input logic w, input logic [5:0] ix, input logic [63:0] wd,
                         input logic [63:0] er, input logic ee, input logic ef, input string nm);
        int guard = 0;
        @(negedge clk);
        while (ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({nm, "_ready"}, {63'd0, ready}, 64'd1);
        valid = 1'b1; kind = k; we = w; idx = ix; wdata = wd;
        @(posedge clk);
        #1;
        push_exp(er, ee, ef, 1, nm);
        @(negedge clk);
        valid = 1'b0;
        wait_drain(nm);
    endtask

    function automatic logic [63:0] all_outputs_or();
        logic [63:0] acc = 64'd0;
        for (int i = 0; i < 64; i++) begin
            acc = acc | {56'd0, cfg_o[i]} | {10'd0, addr_o[i]};
        end
        return acc;
    endfunction

    initial begin
        int low;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ctrl", {60'd0, resp_valid, resp_err, flush, ready}, 64'h1);
        check("reset_rdata", resp_rdata, 64'd0);
        check("reset_state_zero", all_outputs_or(), 64'd0);

        issue(2'd0, 1'b0, 6'd0, 64'd0, 64'd0, 1'b0, 1'b0, "cfg0_read");
        issue(2'd1, 1'b1, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, "addr3_write");
        check("addr3_live", {10'd0, addr_o[3]}, 64'h003F_FFFF_FFFF_FFFF);
        issue(2'd1, 1'b0, 6'd3, 64'd0, 64'h003F_FFFF_FFFF_FFFF, 1'b0, 1'b0, "addr3_read");
        issue(2'd0, 1'b1, 6'd2, 64'h0000_0000_0000_00EF, 64'd0, 1'b0, 1'b1, "cfg2_write");
`ifdef SPMP_SWITCH_EN
        check("cfg8_live", {56'd0, cfg_o[8]}, 64'h87);
`else
        check("cfg8_live", {56'd0, cfg_o[8]}, 64'h8F);
`endif
        issue(2'd0, 1'b1, 6'd2, 64'h0000_0000_0000_00EF, 64'h8F, 1'b0, 1'b0, "cfg2_same_write");
        issue(2'd0, 1'b1, 6'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, "cfg1_odd_err");
        issue(2'd0, 1'b1, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, "cfg4_range_err");
        issue(2'd1, 1'b1, 6'd16, 64'h1234, 64'd0, 1'b1, 1'b0, "addr16_err");
        issue(2'd0, 1'b0, 6'd0, 64'd0, 64'd0, 1'b0, 1'b0, "cfg0_after_err");
        issue(2'd0, 1'b0, 6'd2, 64'd0, 64'h8F, 1'b0, 1'b0, "cfg2_after_err");
        issue(2'd1, 1'b0, 6'd3, 64'd0, 64'h003F_FFFF_FFFF_FFFF, 1'b0, 1'b0, "addr3_after_err");
        issue(2'd0, 1'b1, 6'd0, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 1'b1, "cfg0_write");
        issue(2'd0, 1'b0, 6'd0, 64'd0, 64'h1102_1304_1506_1788, 1'b0, 1'b0, "cfg0_legal_read");
`ifdef SPMP_SWITCH_EN
        check("sw_off_mode", {62'd0, cfg_o[0].addr_mode}, 64'd0);
        issue(2'd2, 1'b1, 6'd0, 64'd1, 64'd0, 1'b0, 1'b1, "switch_write");
        check("sw_on_mode", {62'd0, cfg_o[0].addr_mode}, 64'd1);
        issue(2'd0, 1'b0, 6'd0, 64'd0, 64'h1102_1304_1506_1788, 1'b0, 1'b0, "cfg0_unmasked_read");
        issue(2'd2, 1'b0, 6'd2, 64'd0, 64'd0, 1'b1, 1'b0, "switch_idx2_err");
`else
        issue(2'd2, 1'b0, 6'd0, 64'd0, 64'd0, 1'b1, 1'b0, "switch_absent_err");
`endif

        // Clear-all with a read held off behind it on a continuously valid request line.
        @(negedge clk);
        valid = 1'b1; kind = 2'd3; we = 1'b0; idx = 6'd0; wdata = 64'd0;
        @(posedge clk);
        #1;
        push_exp(64'd0, 1'b0, 1'b1, 17, "clear_all");
        @(negedge clk);
        kind = 2'd0;
        low = 0;
        while (ready !== 1'b1 && low < 100) begin
            low++;
            @(negedge clk);
        end
        check("clear_ready_low", 64'(low), 64'd17);
        check("clear_outputs_zero", all_outputs_or(), 64'd0);
        @(posedge clk);
        #1;
        push_exp(64'd0, 1'b0, 1'b0, 1, "held_read");
        @(negedge clk);
        valid = 1'b0;
        wait_drain("held_read");
`ifdef SPMP_SWITCH_EN
        issue(2'd2, 1'b0, 6'd0, 64'd0, 64'd0, 1'b0, 1'b0, "switch_cleared");
`endif

        // Reset part-way through a second sweep: no response, IDLE on the next cycle.
        issue(2'd1, 1'b1, 6'd5, 64'h1234, 64'd0, 1'b0, 1'b1, "addr5_write");
        @(negedge clk);
        valid = 1'b1; kind = 2'd3;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {63'd0, ready}, 64'd1);
        check("abort_addr5", {10'd0, addr_o[5]}, 64'd0);
        repeat (25) @(negedge clk);
        check("abort_idle_ctrl", {62'd0, resp_valid, ready}, 64'd1);
        issue(2'd1, 1'b0, 6'd5, 64'd0, 64'd0, 1'b0, 1'b0, "addr5_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end
endmodule
